// File: rtl/meter_pkg.sv
// ---------------------------------------------------------------------------
// meter_pkg
// Shared definitions for the parking-meter 7-segment scan decoder:
//   - active-low segment codes {g,f,e,d,c,b,a} for the digits 0..9
//   - SEG_OFF (all segments dark) and AN_DARK (no digit selected)
//   - digit_t BCD digit type, frame FSM state type
//   - an_select(): decodes a one-hot-low anode vector into a slot index
// ---------------------------------------------------------------------------
package meter_pkg;

    typedef logic [3:0] digit_t;

    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_DARK = 4'hF;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_EMIT    = 2'd1,
        ST_BLANK   = 2'd2
    } frame_state_t;

    typedef struct packed {
        logic       one;   // exactly one anode is driven low
        logic [1:0] idx;   // index of that anode (3 = thousands)
    } an_sel_t;

    function automatic an_sel_t an_select(input logic [3:0] an);
        an_sel_t r;
        r.one = 1'b0;
        r.idx = 2'd0;
        case (an)
            4'b1110: begin r.one = 1'b1; r.idx = 2'd0; end
            4'b1101: begin r.one = 1'b1; r.idx = 2'd1; end
            4'b1011: begin r.one = 1'b1; r.idx = 2'd2; end
            4'b0111: begin r.one = 1'b1; r.idx = 2'd3; end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// ---------------------------------------------------------------------------
// seg_scan_decoder_if
// Bundles the scanned display pins and the decoded results.
//   seg[6:0]    active-low segment cathodes {g,f,e,d,c,b,a}
//   an[3:0]     active-low digit anodes, an[3] = thousands
//   bcd[15:0]   last complete frame {d3,d2,d1,d0}
//   value[13:0] binary of bcd
//   frame_valid one-cycle pulse when bcd/value update
//   blank       display dark for the blank timeout
//   flashing    meter in flash mode
//   digit_err   one-cycle pulse on an unrecognised settled pattern
// master: the side driving the pins (meter or bench)
// slave : the decoder
// ---------------------------------------------------------------------------
interface seg_scan_decoder_if;
    import meter_pkg::*;

    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] bcd;
    logic [13:0] value;
    logic        frame_valid;
    logic        blank;
    logic        flashing;
    logic        digit_err;

    modport master (
        output seg, an,
        input  bcd, value, frame_valid, blank, flashing, digit_err
    );

    modport slave (
        input  seg, an,
        output bcd, value, frame_valid, blank, flashing, digit_err
    );

endinterface

// File: rtl/seg7_to_bcd.sv
// ---------------------------------------------------------------------------
// seg7_to_bcd
// Combinational decode of an active-low 7-segment pattern.
//   seg   in  {g,f,e,d,c,b,a}, active-low
//   digit out BCD digit (0 when not ok)
//   ok    out pattern is one of the ten digit codes
//   off   out all segments dark
// ---------------------------------------------------------------------------
module seg7_to_bcd
    import meter_pkg::*;
(
    input  logic [6:0] seg,
    output digit_t     digit,
    output logic       ok,
    output logic       off
);

    always_comb begin
        digit = 4'd0;
        ok    = 1'b1;
        off   = (seg == SEG_OFF);
        case (seg)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg_scan_decoder
// Monitors the multiplexed 7-segment output of the parking meter, settles
// each digit select, decodes segments back to BCD and reassembles 4-digit
// frames. Also tracks the blank/flash behaviour of the display.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      seg_scan_decoder_if.slave (pins in, decoded results out)
// Parameters:
//   SETTLE         cycles {an,seg} must be stable before a digit latches
//   BLANK_TIMEOUT  consecutive dark cycles that declare the display blank
//   FLASH_WINDOW   cycles flashing is held after leaving blank
// ---------------------------------------------------------------------------
module seg_scan_decoder
    import meter_pkg::*;
#(
    parameter int SETTLE        = 16,
    parameter int BLANK_TIMEOUT = 2_000_000,
    parameter int FLASH_WINDOW  = 300_000_000
) (
    input  logic                clk,
    input  logic                reset_n,
    seg_scan_decoder_if.slave   bus
);

    localparam int SW  = $clog2(SETTLE + 1);
    localparam int DKW = $clog2(BLANK_TIMEOUT + 1);
    localparam int FLW = $clog2(FLASH_WINDOW + 1);

    localparam logic [SW-1:0]  SETTLE_MAX   = SW'(SETTLE);
    localparam logic [SW-1:0]  SETTLE_LATCH = SW'(SETTLE - 1);
    localparam logic [DKW-1:0] DARK_MAX     = DKW'(BLANK_TIMEOUT);
    localparam logic [FLW-1:0] FLASH_MAX    = FLW'(FLASH_WINDOW);

    function automatic logic [13:0] bcd_to_bin(input logic [15:0] b);
        return 14'(b[15:12]) * 14'd1000 + 14'(b[11:8]) * 14'd100
             + 14'(b[7:4]) * 14'd10 + 14'(b[3:0]);
    endfunction

    // two-flop synchroniser
    logic [6:0]  seg_s1_q, seg_s2_q;
    logic [3:0]  an_s1_q,  an_s2_q;

    logic [SW-1:0]  settle_q,  settle_d;
    logic [15:0]    slot_q,    slot_d;
    logic [3:0]     seen_q,    seen_d;
    logic [DKW-1:0] dark_q,    dark_d;
    logic [FLW-1:0] flash_q,   flash_d;
    frame_state_t   state_q,   state_d;
    logic [15:0]    bcd_q,     bcd_d;
    logic [13:0]    value_q,   value_d;
    logic           frame_valid_q, frame_valid_d;
    logic           blank_q,       blank_d;
    logic           flashing_q,    flashing_d;
    logic           digit_err_q,   digit_err_d;

    digit_t  dec_digit;
    logic    dec_ok;
    logic    dec_off;
    an_sel_t sel;
    logic    latch_evt;
    logic    valid_latch;
    logic    bad_latch;
    logic [3:0] seen_nxt;
    logic    emit;

    seg7_to_bcd u_dec (
        .seg   (seg_s2_q),
        .digit (dec_digit),
        .ok    (dec_ok),
        .off   (dec_off)
    );

    always_comb begin
        sel = an_select(an_s2_q);

        // Clear when the synced value is about to change, so the count
        // equals the number of cycles the current synced value has been held.
        if ((an_s1_q != an_s2_q) || (seg_s1_q != seg_s2_q))
            settle_d = '0;
        else if (settle_q == SETTLE_MAX)
            settle_d = settle_q;
        else
            settle_d = settle_q + SW'(1);

        latch_evt   = (settle_q == SETTLE_LATCH);
        valid_latch = latch_evt && sel.one && dec_ok;
        bad_latch   = latch_evt && sel.one && !dec_ok && !dec_off;

        slot_d   = slot_q;
        seen_nxt = seen_q;
        if (valid_latch) begin
            slot_d[{sel.idx, 2'b00} +: 4] = dec_digit;
            seen_nxt[sel.idx] = 1'b1;
        end
        if (bad_latch)
            seen_nxt[sel.idx] = 1'b0;

        if (valid_latch)
            dark_d = '0;
        else if ((an_s2_q != AN_DARK) && !dec_off)
            dark_d = '0;
        else if (dark_q == DARK_MAX)
            dark_d = dark_q;
        else
            dark_d = dark_q + DKW'(1);

        flash_d = (flash_q == '0) ? flash_q : flash_q - FLW'(1);

        // Emit is decided on the post-latch occupancy so the frame appears
        // on the edge that completes the fourth digit.
        emit          = (seen_nxt == 4'hF);
        state_d       = state_q;
        seen_d        = seen_nxt;
        bcd_d         = bcd_q;
        value_d       = value_q;
        frame_valid_d = 1'b0;
        blank_d       = blank_q;
        digit_err_d   = bad_latch;

        case (state_q)
            ST_BLANK: begin
                if (emit) begin
                    blank_d = 1'b0;
                    flash_d = FLASH_MAX;
                end
            end
            ST_EMIT: begin
                state_d = ST_COLLECT;
            end
            default: begin
                // a latch in the same cycle as the timeout keeps us out of BLANK
                if (!emit && !valid_latch && (dark_q == DARK_MAX)) begin
                    state_d = ST_BLANK;
                    blank_d = 1'b1;
                    seen_d  = 4'h0;
                end
            end
        endcase

        if (emit) begin
            state_d       = ST_EMIT;
            seen_d        = 4'h0;
            bcd_d         = slot_d;
            value_d       = bcd_to_bin(slot_d);
            frame_valid_d = 1'b1;
        end

        flashing_d = (flash_d != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_s1_q      <= '0;
            seg_s2_q      <= '0;
            an_s1_q       <= '0;
            an_s2_q       <= '0;
            settle_q      <= '0;
            slot_q        <= '0;
            seen_q        <= '0;
            dark_q        <= '0;
            flash_q       <= '0;
            state_q       <= ST_COLLECT;
            bcd_q         <= '0;
            value_q       <= '0;
            frame_valid_q <= 1'b0;
            blank_q       <= 1'b0;
            flashing_q    <= 1'b0;
            digit_err_q   <= 1'b0;
        end else begin
            seg_s1_q      <= bus.seg;
            seg_s2_q      <= seg_s1_q;
            an_s1_q       <= bus.an;
            an_s2_q       <= an_s1_q;
            settle_q      <= settle_d;
            slot_q        <= slot_d;
            seen_q        <= seen_d;
            dark_q        <= dark_d;
            flash_q       <= flash_d;
            state_q       <= state_d;
            bcd_q         <= bcd_d;
            value_q       <= value_d;
            frame_valid_q <= frame_valid_d;
            blank_q       <= blank_d;
            flashing_q    <= flashing_d;
            digit_err_q   <= digit_err_d;
        end
    end

    assign bus.bcd         = bcd_q;
    assign bus.value       = value_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.blank       = blank_q;
    assign bus.flashing    = flashing_q;
    assign bus.digit_err   = digit_err_q;

endmodule
